bp_update_ctrl: RTL and testbench

//  Sequences the branch-predictor counter table. Buffers resolved-branch records from execute and issues them to the

---
 rtl/bp_update_ctrl.sv | 141 ++++++++++++++
 tb/tb_bp_update_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update sequencer: buffers resolved branches, issues one table update per cycle,
// sweeps the counter table to INIT_VAL after reset or a clear request, and keeps issue statistics.
module bp_update_ctrl #(
  parameter int unsigned AWIDTH   = 10,
  parameter int unsigned DEPTH    = 4,
  parameter logic [1:0]  INIT_VAL = 2'b01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_valid,
  output logic                     br_ready,
  input  logic [31:0]              br_pc,
  input  logic                     br_taken,
  input  logic                     br_pred,
  input  logic                     clear_req,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic                     upd_taken,
  output logic                     init_we,
  output logic [AWIDTH-1:0]        init_idx,
  output logic [1:0]               init_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              total_cnt,
  output logic [31:0]              miss_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullCnt = LW'(DEPTH);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [31:0]       total_cnt_q, total_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  // Record storage: {pc, taken, pred}; contents need no reset, occupancy lives in count_q.
  logic [33:0] mem [DEPTH];
  logic [33:0] head;

  logic in_run, full, empty, push, pop;

  assign in_run = (state_q == StRun);
  assign full   = (count_q == FullCnt);
  assign empty  = (count_q == '0);
  assign head   = mem[rd_ptr_q];

  // A clear request wins over both sides of the FIFO in its own cycle.
  assign push = br_valid & br_ready & ~clear_req;
  assign pop  = upd_valid;

  assign br_ready  = rst & ~full;
  assign upd_valid = rst & in_run & ~empty & ~clear_req;
  assign upd_pc    = head[33:2];
  assign upd_taken = head[1];
  assign init_we   = rst & ~in_run;
  assign init_idx  = idx_q;
  assign init_data = INIT_VAL;
  assign busy      = ~in_run;
  assign level     = count_q;
  assign total_cnt = total_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear_req) begin
      state_d = StInit;
      idx_d   = '0;
    end else begin
      case (state_q)
        StInit: begin
          idx_d = idx_q + AWIDTH'(1);
          if (idx_q == '1) state_d = StRun;
        end
        StRun:   state_d = StRun;
        default: state_d = StInit;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) begin
        count_d = count_q + LW'(1);
      end else if (pop && !push) begin
        count_d = count_q - LW'(1);
      end
    end
  end

  // Statistics saturate rather than wrap.
  always_comb begin
    total_cnt_d = total_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (pop) begin
      if (total_cnt_q != '1) total_cnt_d = total_cnt_q + 32'd1;
      if ((head[1] != head[0]) && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      total_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      total_cnt_q <= total_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {br_pc, br_taken, br_pred};
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a queue-based reference model checked every cycle.
module tb_bp_update_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DP = 4;
  localparam logic [1:0]  IV = 2'b01;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          br_valid = 1'b0;
  logic          br_ready;
  logic [31:0]   br_pc = 32'd0;
  logic          br_taken = 1'b0;
  logic          br_pred = 1'b0;
  logic          clear_req = 1'b0;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic          init_we;
  logic [AW-1:0] init_idx;
  logic [1:0]    init_data;
  logic          busy;
  logic [2:0]    level;
  logic [31:0]   total_cnt;
  logic [31:0]   miss_cnt;

  bp_update_ctrl #(
    .AWIDTH  (AW),
    .DEPTH   (DP),
    .INIT_VAL(IV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .br_valid (br_valid),
    .br_ready (br_ready),
    .br_pc    (br_pc),
    .br_taken (br_taken),
    .br_pred  (br_pred),
    .clear_req(clear_req),
    .upd_valid(upd_valid),
    .upd_pc   (upd_pc),
    .upd_taken(upd_taken),
    .init_we  (init_we),
    .init_idx (init_idx),
    .init_data(init_data),
    .busy     (busy),
    .level    (level),
    .total_cnt(total_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending records as a queue, sweep as a plain counter.
  typedef struct packed {
    logic [31:0] pc;
    logic        t;
    logic        p;
  } rec_t;

  rec_t        mq[$];
  bit          m_init = 1'b1;
  int          m_idx = 0;
  logic [31:0] m_total = 32'd0;
  logic [31:0] m_miss = 32'd0;
  int          preload_tog = 0;
  int          preload_seen = 0;

  always @(posedge clk or negedge rst or preload_tog) begin
    rec_t h;
    rec_t r;
    bit   do_pop;
    bit   do_push;
    if (!rst) begin
      mq.delete();
      m_init  = 1'b1;
      m_idx   = 0;
      m_total = 32'd0;
      m_miss  = 32'd0;
    end else if (preload_tog != preload_seen) begin
      preload_seen = preload_tog;
      m_total      = 32'hFFFF_FFFF;
      m_miss       = 32'hFFFF_FFFF;
    end else if (clear_req) begin
      mq.delete();
      m_init = 1'b1;
      m_idx  = 0;
    end else begin
      do_pop  = !m_init && (mq.size() > 0);
      do_push = br_valid && (mq.size() < DP);
      if (do_pop) begin
        h = mq.pop_front();
        if (m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
        if (h.t != h.p && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
      end
      if (do_push) begin
        r.pc = br_pc;
        r.t  = br_taken;
        r.p  = br_pred;
        mq.push_back(r);
      end
      if (m_init) begin
        if (m_idx == (1 << AW) - 1) m_init = 1'b0;
        m_idx = m_idx + 1;
      end
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  int          we_seen = 0;
  logic [31:0] issued[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_all();
    bit e_we;
    bit e_uv;
    e_we = rst && m_init;
    e_uv = rst && !m_init && (mq.size() > 0) && !clear_req;
    chk("busy", 32'(busy), 32'(!rst || m_init));
    chk("init_we", 32'(init_we), 32'(e_we));
    chk("br_ready", 32'(br_ready), 32'(rst && mq.size() < DP));
    chk("upd_valid", 32'(upd_valid), 32'(e_uv));
    chk("level", 32'(level), 32'(mq.size()));
    chk("init_data", 32'(init_data), 32'(IV));
    chk("total_cnt", total_cnt, m_total);
    chk("miss_cnt", miss_cnt, m_miss);
    if (e_we) chk("init_idx", 32'(init_idx), 32'(m_idx));
    if (e_uv) begin
      chk("upd_pc", upd_pc, mq[0].pc);
      chk("upd_taken", 32'(upd_taken), 32'(mq[0].t));
    end
    if (init_we) we_seen++;
    if (upd_valid) issued.push_back(upd_pc);
  endtask

  task automatic cyc(input bit v, input logic [31:0] pc, input bit t, input bit p, input bit clr);
    @(negedge clk);
    br_valid  = v;
    br_pc     = pc;
    br_taken  = t;
    br_pred   = p;
    clear_req = clr;
    #2;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst       = 1'b1;
    br_valid  = 1'b0;
    clear_req = 1'b0;
    #2;
    check_all();
  endtask

  task automatic wait_run();
    int g;
    g = 0;
    while (busy && g < 40) begin
      idle();
      g++;
    end
    chk("sweep_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    // Power-up reset.
    #3;
    check_all();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(br_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    idle();
    idle();

    // Sweep with five back-to-back pushes during INIT.
    we_seen = 0;
    issued.delete();
    release_rst();
    chk("sweep_first_idx", 32'(init_idx), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h100 + 32'(i), i[0], i[0], 1'b0);
      if (i == 4) begin
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(br_ready), 32'd0);
      end
    end
    wait_run();
    chk("sweep_len", 32'(we_seen), 32'd16);
    for (int i = 0; i < 3; i++) idle();
    idle();
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_count", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < issued.size()) chk("drain_order", issued[i], 32'h100 + 32'(i));
    end
    chk("drain_total", total_cnt, 32'd4);
    chk("drain_miss", miss_cnt, 32'd0);

    // Single mispredict, empty FIFO.
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    idle();
    chk("lat_valid", 32'(upd_valid), 32'd1);
    chk("lat_pc", upd_pc, 32'h40);
    chk("lat_taken", 32'(upd_taken), 32'd1);
    idle();
    chk("lat_total", total_cnt, 32'd5);
    chk("lat_miss", miss_cnt, 32'd1);

    // Steady push every cycle.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h200 + 32'(i), i[0], (i % 3) == 0, 1'b0);
      chk("steady_level", 32'(level <= 3'd1), 32'd1);
    end
    idle();
    idle();
    chk("steady_total", total_cnt, 32'd13);
    chk("steady_miss", miss_cnt, 32'd6);

    // Clear with level 3 in RUN and a push in the same cycle.
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) idle();
    cyc(1'b1, 32'h3FF, 1'b1, 1'b1, 1'b1);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_level_before", 32'(level), 32'd3);
    chk("clr_no_issue", 32'(upd_valid), 32'd0);
    idle();
    chk("clr_level_after", 32'(level), 32'd0);
    chk("clr_restart_we", 32'(init_we), 32'd1);
    chk("clr_restart_idx", 32'(init_idx), 32'd0);
    chk("clr_total", total_cnt, 32'd13);
    chk("clr_miss", miss_cnt, 32'd6);

    // Clear during INIT restarts the sweep.
    for (int i = 0; i < 5; i++) idle();
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("reclr_idx", 32'(init_idx), 32'd0);
    wait_run();

    // Saturation of both statistics.
    @(negedge clk);
    force dut.total_cnt_q = 32'hFFFF_FFFF;
    force dut.miss_cnt_q  = 32'hFFFF_FFFF;
    preload_tog++;
    #1;
    release dut.total_cnt_q;
    release dut.miss_cnt_q;
    cyc(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("sat_total", total_cnt, 32'hFFFF_FFFF);
    chk("sat_miss", miss_cnt, 32'hFFFF_FFFF);
    cyc(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    chk("sat_total2", total_cnt, 32'hFFFF_FFFF);

    // Asynchronous reset mid-sweep.
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h600 + 32'(i), 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all();
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_we", 32'(init_we), 32'd0);
    chk("arst_ready", 32'(br_ready), 32'd0);
    chk("arst_valid", 32'(upd_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_total", total_cnt, 32'd0);
    chk("arst_miss", miss_cnt, 32'd0);
    idle();
    we_seen = 0;
    release_rst();
    wait_run();
    chk("resweep_len", 32'(we_seen), 32'd16);
    cyc(1'b1, 32'h700, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    chk("post_total", total_cnt, 32'd1);
    chk("post_miss", miss_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
